mem_access: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline; consumes the EXE→MEM bus and produces the MEM→WB bus. It issues load/store requests to the data memory over a req/ack handshake, aligns byte lanes, and holds the stage until the access completes. Non-memory instructions pass through with zero added latency.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_lane_align.sv | 26 ++
 rtl/mem_access.sv | 136 +++++++++++++
 tb/tb_mem_access.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MEM pipeline stage: bus widths, mem_control bit
// positions and the access FSM state encoding.
package mem_pkg;

    localparam int EXE_MEM_W = 154;
    localparam int MEM_WB_W  = 118;

    // Bit positions inside the 4-bit mem_control field
    localparam int MC_LOAD  = 3;
    localparam int MC_STORE = 2;
    localparam int MC_WORD  = 1;
    localparam int MC_SEXT  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_access_if;

    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane handling for the MEM stage: store write-enable/data replication
// and load lane extraction with optional sign extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  byte_sel,
    input  logic        word,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] lane;

    // Word accesses use all lanes; byte accesses pick the lane given by addr[1:0]
    always_comb begin
        we        = word ? 4'b1111 : (4'b0001 << byte_sel);
        wdata     = word ? store_data : {4{store_data[7:0]}};
        lane      = rdata[{byte_sel, 3'b000} +: 8];
        load_data = word ? rdata : {{24{sign_ext & lane[7]}}, lane};
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the five-stage MIPS pipeline. Issues data-memory requests,
// aligns byte lanes and holds the instruction until the access completes.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned word accesses are trapped
// (no request, mem_align_err raised) instead of being silently word-aligned.
module mem_access
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MEM_valid,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
    input  logic                 WB_allow_in,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          MEM_pc,
    output logic                 mem_align_err,
    mem_access_if.master         dm
);

    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic [5:0]  hilo_cp0_flags;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;

    assign {mem_control, store_data, exe_result, lo_result, hilo_cp0_flags,
            cp0r_addr, syscall, eret, rf_wen, rf_wdest, pc} = EXE_MEM_bus_r;

    logic is_load, is_store, is_word, is_mem, misalign, do_access;

    assign is_load  = mem_control[MC_LOAD];
    assign is_store = mem_control[MC_STORE];
    assign is_word  = mem_control[MC_WORD];
    assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign    = is_mem & is_word & (|exe_result[1:0]);
    assign dm.dm_addr  = exe_result;
`else
    assign misalign    = 1'b0;
    assign dm.dm_addr  = is_word ? {exe_result[31:2], 2'b00} : exe_result;
`endif

    assign do_access = is_mem & ~misalign;

    mem_state_t  state, state_nxt;
    logic [31:0] rdata_r;
    logic        req, over, latch;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata, load_data;

    mem_lane_align u_lane (
        .byte_sel   (exe_result[1:0]),
        .word       (is_word),
        .sign_ext   (mem_control[MC_SEXT]),
        .store_data (store_data),
        .rdata      (rdata_r),
        .we         (lane_we),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    // State register and read-data capture on the accepting ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_r <= 32'd0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                rdata_r <= dm.dm_rdata;
            end
        end
    end

    // Next state, request and completion; an ack with no request is ignored
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        over      = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_valid) begin
                    if (do_access) begin
                        req = 1'b1;
                        if (dm.dm_ack) begin
                            latch     = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end else begin
                        over = 1'b1;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dm.dm_ack) begin
                    latch     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                over = 1'b1;
                if (WB_allow_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dm.dm_req   = req & ~rst;
    assign dm.dm_we    = (req & ~rst & is_store) ? lane_we : 4'b0000;
    assign dm.dm_wdata = lane_wdata;
    assign MEM_over    = over & ~rst;

    logic [31:0] mem_result;
    assign mem_result    = (is_load & ~misalign) ? load_data : exe_result;
    assign mem_align_err = MEM_valid & misalign;

    assign MEM_WB_bus = {rf_wen, rf_wdest, mem_result, lo_result, hilo_cp0_flags,
                         cp0r_addr, syscall, eret, pc};
    assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
    assign MEM_pc     = pc;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access with a scoreboard of expected MEM_WB_bus
// values. Honours MEM_ALIGN_CHECK_EN for the misaligned word load step.
module tb_mem_access;
    import mem_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 MEM_valid;
    logic [EXE_MEM_W-1:0] EXE_MEM_bus_r;
    logic                 WB_allow_in;
    logic                 MEM_over;
    logic [MEM_WB_W-1:0]  MEM_WB_bus;
    logic [4:0]           MEM_wdest;
    logic [31:0]          MEM_pc;
    logic                 mem_align_err;

    mem_access_if dm_bus ();

    mem_access dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_valid     (MEM_valid),
        .EXE_MEM_bus_r (EXE_MEM_bus_r),
        .WB_allow_in   (WB_allow_in),
        .MEM_over      (MEM_over),
        .MEM_WB_bus    (MEM_WB_bus),
        .MEM_wdest     (MEM_wdest),
        .MEM_pc        (MEM_pc),
        .mem_align_err (mem_align_err),
        .dm            (dm_bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [MEM_WB_W-1:0] sb[$];

    localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

    // Side fields derived from pc so that each instruction carries a distinct pattern
    function automatic logic [EXE_MEM_W-1:0] make_exe(input logic [3:0] mc, input logic [31:0] sd,
            input logic [31:0] exe, input logic wen, input logic [4:0] wdest, input logic [31:0] pc);
        return {mc, sd, exe, 32'h0C0C_0000 ^ pc, 6'b101001, 8'h5A ^ pc[7:0], 1'b0, 1'b1, wen, wdest, pc};
    endfunction

    function automatic logic [MEM_WB_W-1:0] make_wb(input logic [31:0] res, input logic wen,
            input logic [4:0] wdest, input logic [31:0] pc);
        return {wen, wdest, res, 32'h0C0C_0000 ^ pc, 6'b101001, 8'h5A ^ pc[7:0], 1'b0, 1'b1, pc};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkScoreboard(input string tag);
        logic [MEM_WB_W-1:0] exp;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL %s observed=MEM_over expected=empty scoreboard", tag);
        end else begin
            exp = sb.pop_front();
            assert (MEM_WB_bus === exp) passed++;
            else $error("FAIL %s observed=%0h expected=%0h", tag, MEM_WB_bus, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] mc, input logic [31:0] sd,
            input logic [31:0] exe, input logic wen, input logic [4:0] wdest, input logic [31:0] pc,
            input logic exp_req, input int waits, input logic [31:0] rdata,
            input logic [3:0] exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
            input logic [31:0] exp_result, input logic exp_err, input int hold);
        logic [MEM_WB_W-1:0] exp_wb;
        exp_wb = make_wb(exp_result, wen, wdest, pc);
        @(posedge clk); #1;
        MEM_valid       = 1'b1;
        EXE_MEM_bus_r   = make_exe(mc, sd, exe, wen, wdest, pc);
        WB_allow_in     = (hold == 0);
        dm_bus.dm_ack   = exp_req && (waits == 0);
        dm_bus.dm_rdata = (waits == 0) ? rdata : JUNK;
        sb.push_back(exp_wb);
        @(negedge clk);
        checkOutput({tag, ".wdest"}, 128'(MEM_wdest), 128'(wdest));
        checkOutput({tag, ".align_err"}, 128'(mem_align_err), 128'(exp_err));
        if (exp_req) begin
            for (int i = 0; i <= waits; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                    dm_bus.dm_ack   = (i == waits);
                    dm_bus.dm_rdata = (i == waits) ? rdata : JUNK;
                    @(negedge clk);
                end
                checkOutput({tag, ".req"}, 128'(dm_bus.dm_req), 128'(1'b1));
                checkOutput({tag, ".we"}, 128'(dm_bus.dm_we), 128'(exp_we));
                checkOutput({tag, ".addr"}, 128'(dm_bus.dm_addr), 128'(exp_addr));
                if (exp_we != 4'b0000)
                    checkOutput({tag, ".wdata"}, 128'(dm_bus.dm_wdata), 128'(exp_wdata));
                checkOutput({tag, ".over_early"}, 128'(MEM_over), 128'(1'b0));
            end
            @(posedge clk); #1;
            dm_bus.dm_ack   = 1'b0;
            dm_bus.dm_rdata = JUNK;
            @(negedge clk);
        end
        checkOutput({tag, ".req_off"}, 128'(dm_bus.dm_req), 128'(1'b0));
        checkOutput({tag, ".over"}, 128'(MEM_over), 128'(1'b1));
        checkScoreboard({tag, ".bus"});
        for (int j = 1; j <= hold; j++) begin
            @(posedge clk); #1;
            if (j == hold) WB_allow_in = 1'b1;
            @(negedge clk);
            checkOutput({tag, ".hold_over"}, 128'(MEM_over), 128'(1'b1));
            checkOutput({tag, ".hold_bus"}, 128'(MEM_WB_bus), 128'(exp_wb));
            checkOutput({tag, ".hold_req"}, 128'(dm_bus.dm_req), 128'(1'b0));
        end
        @(posedge clk); #1;
        MEM_valid   = 1'b0;
        WB_allow_in = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".retired"}, 128'(MEM_over), 128'(1'b0));
        checkOutput({tag, ".idle_req"}, 128'(dm_bus.dm_req), 128'(1'b0));
    endtask

    initial begin
        // Reset with a memory instruction and an ack present: everything must stay quiet
        rst             = 1'b1;
        MEM_valid       = 1'b1;
        EXE_MEM_bus_r   = make_exe(4'b1010, 32'd0, 32'h100, 1'b1, 5'd2, 32'h400);
        WB_allow_in     = 1'b1;
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = JUNK;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.req", 128'(dm_bus.dm_req), 128'(1'b0));
        checkOutput("reset.we", 128'(dm_bus.dm_we), 128'(4'b0000));
        checkOutput("reset.over", 128'(MEM_over), 128'(1'b0));
        @(posedge clk); #1;
        rst           = 1'b0;
        MEM_valid     = 1'b0;
        dm_bus.dm_ack = 1'b0;

        // Plain ALU op: completes combinationally, no request
        applyStimulus("alu", 4'b0000, 32'h0, 32'h1234, 1'b1, 5'd5, 32'h1000,
                      1'b0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0000_1234, 1'b0, 0);

        // Stray ack with no request must not move the FSM
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b1;
        @(negedge clk);
        checkOutput("stray_ack.over", 128'(MEM_over), 128'(1'b0));
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b0;
        @(negedge clk);
        checkOutput("stray_ack.over2", 128'(MEM_over), 128'(1'b0));

        applyStimulus("lw", 4'b1010, 32'h0, 32'h100, 1'b1, 5'd8, 32'h1004,
                      1'b1, 0, 32'hDEAD_BEEF, 4'h0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        applyStimulus("lb", 4'b1001, 32'h0, 32'h103, 1'b1, 5'd9, 32'h1008,
                      1'b1, 3, 32'h80FF_FFFF, 4'h0, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 4);
        applyStimulus("lbu", 4'b1000, 32'h0, 32'h103, 1'b1, 5'd10, 32'h100C,
                      1'b1, 1, 32'h80FF_FFFF, 4'h0, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 0);
        applyStimulus("lbu1", 4'b1000, 32'h0, 32'h101, 1'b1, 5'd11, 32'h1010,
                      1'b1, 0, 32'h1234_5678, 4'h0, 32'h101, 32'h0, 32'h0000_0056, 1'b0, 0);
        applyStimulus("sb", 4'b0100, 32'h1234_56AB, 32'h102, 1'b0, 5'd0, 32'h1014,
                      1'b1, 2, JUNK, 4'b0100, 32'h102, 32'hABAB_ABAB, 32'h0000_0102, 1'b0, 0);
        applyStimulus("sw", 4'b0110, 32'hCAFE_F00D, 32'h200, 1'b0, 5'd0, 32'h1018,
                      1'b1, 0, JUNK, 4'b1111, 32'h200, 32'hCAFE_F00D, 32'h0000_0200, 1'b0, 1);
`ifdef MEM_ALIGN_CHECK_EN
        applyStimulus("lw_mis", 4'b1010, 32'h0, 32'h101, 1'b1, 5'd12, 32'h101C,
                      1'b0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0000_0101, 1'b1, 0);
`else
        applyStimulus("lw_mis", 4'b1010, 32'h0, 32'h101, 1'b1, 5'd12, 32'h101C,
                      1'b1, 0, 32'h5566_7788, 4'h0, 32'h100, 32'h0, 32'h5566_7788, 1'b0, 0);
`endif

        // Reset while waiting: request dropped, late ack ignored
        @(posedge clk); #1;
        MEM_valid     = 1'b1;
        EXE_MEM_bus_r = make_exe(4'b1010, 32'h0, 32'h300, 1'b1, 5'd13, 32'h1020);
        @(negedge clk);
        checkOutput("rstwait.req", 128'(dm_bus.dm_req), 128'(1'b1));
        @(posedge clk); #1;
        checkOutput("rstwait.req_wait", 128'(dm_bus.dm_req), 128'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstwait.req_rst", 128'(dm_bus.dm_req), 128'(1'b0));
        @(posedge clk); #1;
        rst           = 1'b0;
        MEM_valid     = 1'b0;
        dm_bus.dm_ack = 1'b1;
        @(negedge clk);
        checkOutput("rstwait.late_req", 128'(dm_bus.dm_req), 128'(1'b0));
        checkOutput("rstwait.late_over", 128'(MEM_over), 128'(1'b0));
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b0;
        @(negedge clk);
        checkOutput("rstwait.after_over", 128'(MEM_over), 128'(1'b0));

        // Normal operation resumes after the abandoned access
        applyStimulus("lw_after", 4'b1010, 32'h0, 32'h304, 1'b1, 5'd14, 32'h1024,
                      1'b1, 1, 32'h0F0F_1234, 4'h0, 32'h304, 32'h0, 32'h0F0F_1234, 1'b0, 0);

        checkOutput("sb.empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
